// File: rtl/regfile_pkg.sv
// Shared register-file types and constants.
// Used by regfile_mp, decode and the hazard unit.
package regfile_pkg;

  typedef enum logic {
    RF_INIT,
    RF_READY
  } rf_state_e;

  localparam int RF_WIDTH  = 32;
  localparam int RF_DEPTH  = 32;
  localparam int RF_NUM_RD = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register,
// set by reservation, cleared by writeback.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = RF_DEPTH,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int ZERO_REG = 1,
  parameter int AW       = clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic                 i_we,
  input  logic [AW-1:0]        i_wa,
  input  logic                 i_rsv_en,
  input  logic [AW-1:0]        i_rsv_addr,
  input  logic [NUM_RD*AW-1:0] i_ra,
  output logic [NUM_RD-1:0]    o_pend,
  output logic                 o_rsv_err
);

  logic [DEPTH-1:0] r_bits;
  logic             r_err;
  logic             w_clr;
  logic             w_set;
  logic             w_err;
  logic             w_rsv_zero;

  assign w_rsv_zero = (ZERO_REG != 0) && (i_rsv_addr == '0);
  assign w_clr = i_en && i_we;
  assign w_set = i_en && i_rsv_en && !w_rsv_zero;

  // A reservation that lands on a pending register
  // is flagged unless writeback retires it now.
  assign w_err = w_set && r_bits[i_rsv_addr]
              && !(i_we && (i_wa == i_rsv_addr));

  // Clear first, then set: a new producer wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bits <= '0;
    end else begin
      if (w_clr) r_bits[i_wa] <= 1'b0;
      if (w_set) r_bits[i_rsv_addr] <= 1'b1;
    end
  end

  // One-cycle error pulse after a double reserve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= w_err;
  end

  assign o_rsv_err = r_err;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_pend
    logic [AW-1:0] w_a;
    assign w_a = i_ra[p*AW +: AW];
    assign o_pend[p] = r_bits[w_a];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with bypass,
// pending-write scoreboard and post-reset clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_RD*AW-1:0]    ra,
  output logic [NUM_RD*WIDTH-1:0] rd,
  output logic [NUM_RD-1:0]       rd_pend,
  input  logic                    we,
  input  logic [AW-1:0]           wa,
  input  logic [WIDTH-1:0]        wd,
  input  logic                    rsv_en,
  input  logic [AW-1:0]           rsv_addr,
  output logic                    rsv_err,
  output logic                    ready
);

  rf_state_e        r_state;
  logic [AW-1:0]    r_cnt;
  logic             r_ready;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_clr;
  logic             w_wr;
  logic [NUM_RD-1:0] w_pend;

  assign w_clr = (r_state == RF_INIT);
  assign w_wr  = r_ready && we
              && !((ZERO_REG != 0) && (wa == '0));

  // Clear sequencer: one register per cycle, then hold READY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RF_INIT;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        RF_INIT: begin
          if (r_cnt == AW'(DEPTH-1)) begin
            r_state <= RF_READY;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RF_READY: r_ready <= 1'b1;
        default: begin
          r_state <= RF_INIT;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage: clear writes during INIT, writeback after.
  always_ff @(posedge clk) begin
    if (w_clr)     r_mem[r_cnt] <= '0;
    else if (w_wr) r_mem[wa]    <= wd;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]    w_a;
    logic [WIDTH-1:0] w_rd;
    assign w_a = ra[p*AW +: AW];

    // Read mux: masked, hard zero, bypass, then array.
    always_comb begin
      w_rd = '0;
      if (!r_ready)
        w_rd = '0;
      else if ((ZERO_REG != 0) && (w_a == '0))
        w_rd = '0;
      else if ((BYPASS != 0) && w_wr && (wa == w_a))
        w_rd = wd;
      else
        w_rd = r_mem[w_a];
    end

    assign rd[p*WIDTH +: WIDTH] = w_rd;
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (r_ready),
    .i_we       (we),
    .i_wa       (wa),
    .i_rsv_en   (rsv_en),
    .i_rsv_addr (rsv_addr),
    .i_ra       (ra),
    .o_pend     (w_pend),
    .o_rsv_err  (rsv_err)
  );

  assign rd_pend = r_ready ? w_pend : '0;
  assign ready   = r_ready;

endmodule
